// File: rtl/ofs_plat_prim_re_pipe_pkg.sv
// Shared types and helpers for the ready/enable skid pipeline.
// Holds the per-stage state encoding and the occupancy width calculation.
package ofs_plat_prim_re_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FULL1,
    FULL2
  } t_skid_state;

  // Width needed to count 0..2*n_stages beats; never narrower than one bit.
  function automatic int occ_bits(input int n_stages);
    return (n_stages < 1) ? 1 : $clog2(2 * n_stages + 1);
  endfunction

endpackage

// File: rtl/ofs_plat_prim_ready_enable_skid_stage.sv
// One two-entry skid stage: main register plus skid register.
// Ready is decoded from registered state only, so no combinational ready path crosses the stage.
module ofs_plat_prim_ready_enable_skid_stage
  import ofs_plat_prim_re_pipe_pkg::*;
#(
  parameter int N_DATA_BITS = 32
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_in,
  input  logic [N_DATA_BITS-1:0] data_in,
  output logic                   ready_out,
  output logic                   enable_out,
  output logic [N_DATA_BITS-1:0] data_out,
  input  logic                   ready_in
);

  t_skid_state state_q, state_d;
  logic [N_DATA_BITS-1:0] main_q, main_d;
  logic [N_DATA_BITS-1:0] skid_q, skid_d;
  logic in_xfer, out_xfer;

  assign in_xfer  = enable_in && ready_out;
  assign out_xfer = enable_out && ready_in;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_xfer) state_d = FULL1;
      FULL1: begin
        if (in_xfer && !out_xfer)      state_d = FULL2;
        else if (!in_xfer && out_xfer) state_d = EMPTY;
      end
      FULL2: if (out_xfer) state_d = FULL1;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    enable_out = (state_q != EMPTY);
    ready_out  = (state_q != FULL2);
    data_out   = main_q;
  end

  // When full, the skid entry refills main as the head leaves; otherwise input lands in
  // main if main is free (or emptying this cycle) and in skid if main must hold.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (state_q == FULL2) begin
      if (out_xfer) main_d = skid_q;
    end else if (in_xfer) begin
      if ((state_q == EMPTY) || out_xfer) main_d = data_in;
      else                                skid_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/ofs_plat_prim_ready_enable_pipe.sv
// Ready/enable pipeline of N_STAGES skid stages; N_STAGES=0 is a pure wire bypass.
// Define OFS_PLAT_PRIM_RE_PIPE_OCCUPANCY_EN to build the occupancy counter; otherwise it reads 0.
module ofs_plat_prim_ready_enable_pipe
  import ofs_plat_prim_re_pipe_pkg::*;
#(
  parameter  int N_DATA_BITS = 32,
  parameter  int N_STAGES    = 2,
  localparam int OCC_BITS    = occ_bits(N_STAGES)
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_from_src,
  input  logic [N_DATA_BITS-1:0] data_from_src,
  output logic                   ready_to_src,
  output logic                   enable_to_dst,
  output logic [N_DATA_BITS-1:0] data_to_dst,
  input  logic                   ready_from_dst,
  output logic [OCC_BITS-1:0]    occupancy
);

  if (N_STAGES == 0) begin : g_bypass
    wire bypass_unused = &{1'b0, clk, reset};

    assign ready_to_src  = ready_from_dst;
    assign enable_to_dst = enable_from_src;
    assign data_to_dst   = data_from_src;
    assign occupancy     = '0;
  end else begin : g_pipe
    logic                   en_chain   [N_STAGES+1];
    logic                   rdy_chain  [N_STAGES+1];
    logic [N_DATA_BITS-1:0] data_chain [N_STAGES+1];

    assign en_chain[0]         = enable_from_src;
    assign data_chain[0]       = data_from_src;
    assign rdy_chain[N_STAGES] = ready_from_dst;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
      ofs_plat_prim_ready_enable_skid_stage #(
        .N_DATA_BITS(N_DATA_BITS)
      ) stage (
        .clk        (clk),
        .reset      (reset),
        .enable_in  (en_chain[i]),
        .data_in    (data_chain[i]),
        .ready_out  (rdy_chain[i]),
        .enable_out (en_chain[i+1]),
        .data_out   (data_chain[i+1]),
        .ready_in   (rdy_chain[i+1])
      );
    end

    // Stages clear on the reset edge, but the source must also see no accepts while reset is high.
    assign ready_to_src  = rdy_chain[0] && !reset;
    assign enable_to_dst = en_chain[N_STAGES];
    assign data_to_dst   = data_chain[N_STAGES];

`ifdef OFS_PLAT_PRIM_RE_PIPE_OCCUPANCY_EN
    logic [OCC_BITS-1:0] occ_q, occ_d;
    logic src_xfer, dst_xfer;

    assign src_xfer = enable_from_src && ready_to_src;
    assign dst_xfer = enable_to_dst && ready_from_dst;

    always_comb begin
      occ_d = occ_q;
      if (src_xfer && !dst_xfer)      occ_d = occ_q + OCC_BITS'(1);
      else if (!src_xfer && dst_xfer) occ_d = occ_q - OCC_BITS'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) occ_q <= '0;
      else       occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif
  end

endmodule

// File: tb/tb_ofs_plat_prim_ready_enable_pipe.sv
// Directed checks of a 2-stage pipe plus a scoreboarded random stream through 0/1/3-stage pipes.
// Expected occupancy follows OFS_PLAT_PRIM_RE_PIPE_OCCUPANCY_EN (0 when the counter is not built).
module tb_ofs_plat_prim_ready_enable_pipe;
  import ofs_plat_prim_re_pipe_pkg::*;

  localparam int W          = 32;
  localparam int NS         = 2;
  localparam int OCC_W      = occ_bits(NS);
  localparam int RND_BEATS  = 3000;
  localparam int RND_BUDGET = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic enable_from_src = 1'b0;
  logic ready_from_dst = 1'b0;
  logic [W-1:0] data_from_src = '0;
  wire ready_to_src, enable_to_dst;
  wire [W-1:0] data_to_dst;
  wire [OCC_W-1:0] occupancy;

  int check_count = 0;
  int error_count = 0;

  ofs_plat_prim_ready_enable_pipe #(.N_DATA_BITS(W), .N_STAGES(NS)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_from_src (enable_from_src),
    .data_from_src   (data_from_src),
    .ready_to_src    (ready_to_src),
    .enable_to_dst   (enable_to_dst),
    .data_to_dst     (data_to_dst),
    .ready_from_dst  (ready_from_dst),
    .occupancy       (occupancy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int exp_occ(input int n);
`ifdef OFS_PLAT_PRIM_RE_PIPE_OCCUPANCY_EN
    return n;
`else
    return n * 0;
`endif
  endfunction

  // Drive one cycle of inputs on the falling edge, then settle before any sampling.
  task automatic applyStimulus(input logic en, input logic [W-1:0] data, input logic rdy);
    @(negedge clk);
    enable_from_src = en;
    data_from_src   = data;
    ready_from_dst  = rdy;
    #1;
  endtask

  // Random-traffic pipes of depth 0, 1 and 3, each with its own source and in-order scoreboard.
  logic rnd_reset = 1'b1;
  logic rnd_phase = 1'b0;
  wire [2:0] rnd_done;

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int RNS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic en = 1'b0;
    logic rdy = 1'b0;
    logic [15:0] data = '0;
    wire rdy_src, en_dst;
    wire [15:0] data_dst;
    wire [occ_bits(RNS)-1:0] occ;
    int src_count = 0;
    int rcv_count = 0;

    ofs_plat_prim_ready_enable_pipe #(.N_DATA_BITS(16), .N_STAGES(RNS)) rdut (
      .clk             (clk),
      .reset           (rnd_reset),
      .enable_from_src (en),
      .data_from_src   (data),
      .ready_to_src    (rdy_src),
      .enable_to_dst   (en_dst),
      .data_to_dst     (data_dst),
      .ready_from_dst  (rdy),
      .occupancy       (occ)
    );

    always @(negedge clk) begin
      if (rnd_phase) begin
        en   = (src_count < RND_BEATS) && ($urandom_range(1, 0) == 1);
        data = 16'(src_count);
        rdy  = ($urandom_range(1, 0) == 1);
        #1;
        checkOutput($sformatf("rnd%0d_occ", RNS), 64'(occ),
                    64'((RNS == 0) ? 0 : exp_occ(src_count - rcv_count)));
        if (en && rdy_src) src_count++;
        if (en_dst && rdy) begin
          checkOutput($sformatf("rnd%0d_data", RNS), 64'(data_dst), 64'(16'(rcv_count)));
          rcv_count++;
        end
      end
    end

    assign rnd_done[g] = (rcv_count == RND_BEATS);
  end

  initial begin
    int accepted;

    // Reset: no accepts while reset is high, empty and ready once it drops.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_rdy_low", 64'(ready_to_src), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_rdy_high", 64'(ready_to_src), 64'd1);
    checkOutput("rst_en", 64'(enable_to_dst), 64'd0);
    checkOutput("rst_occ", 64'(occupancy), 64'd0);

    // Stream 0..99 with the sink always ready: two-cycle latency, one beat per clock.
    for (int cyc = 0; cyc < 104; cyc++) begin
      applyStimulus(cyc < 100, W'(cyc), 1'b1);
      if (cyc >= 2 && cyc < 102) begin
        checkOutput("stream_en", 64'(enable_to_dst), 64'd1);
        checkOutput("stream_data", 64'(data_to_dst), 64'(cyc - 2));
      end else begin
        checkOutput("stream_idle", 64'(enable_to_dst), 64'd0);
      end
      checkOutput("stream_rdy", 64'(ready_to_src), 64'd1);
      if (cyc == 1)   checkOutput("stream_occ1", 64'(occupancy), 64'(exp_occ(1)));
      if (cyc == 50)  checkOutput("stream_occ2", 64'(occupancy), 64'(exp_occ(2)));
      if (cyc == 103) checkOutput("stream_occ0", 64'(occupancy), 64'd0);
    end

    // Backpressure: sink stalled, source keeps offering; exactly four beats fit.
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, W'(200 + accepted), 1'b0);
      if (ready_to_src) accepted++;
    end
    checkOutput("fill_count", 64'(accepted), 64'd4);
    checkOutput("fill_rdy", 64'(ready_to_src), 64'd0);
    checkOutput("fill_occ", 64'(occupancy), 64'(exp_occ(4)));
    checkOutput("fill_en", 64'(enable_to_dst), 64'd1);
    checkOutput("fill_head", 64'(data_to_dst), 64'd200);

    // Drain: four consecutive beats, source ready returns two cycles after the sink opens.
    for (int d = 0; d < 5; d++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("drain_en", 64'(enable_to_dst), (d < 4) ? 64'd1 : 64'd0);
      if (d < 4) checkOutput("drain_data", 64'(data_to_dst), 64'(200 + d));
      checkOutput("drain_rdy", 64'(ready_to_src), (d >= 2) ? 64'd1 : 64'd0);
      checkOutput("drain_occ", 64'(occupancy), 64'(exp_occ(4 - d)));
    end

    // Reset in the middle of a stalled burst holding three beats.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'(300 + i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("mid_occ3", 64'(occupancy), 64'(exp_occ(3)));
    checkOutput("mid_en", 64'(enable_to_dst), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_rdy", 64'(ready_to_src), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_en", 64'(enable_to_dst), 64'd0);
    checkOutput("post_rst_occ", 64'(occupancy), 64'd0);
    checkOutput("post_rst_rdy", 64'(ready_to_src), 64'd1);

    // A fresh beat after reset flows normally and nothing stale follows it.
    applyStimulus(1'b1, W'(32'h55), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_lat", 64'(enable_to_dst), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_beat_en", 64'(enable_to_dst), 64'd1);
    checkOutput("post_rst_beat", 64'(data_to_dst), 64'h55);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("post_rst_empty", 64'(enable_to_dst), 64'd0);

    // Random traffic through the 0/1/3-stage pipes, bounded by a cycle budget.
    @(negedge clk);
    rnd_reset = 1'b0;
    rnd_phase = 1'b1;
    for (int i = 0; i < RND_BUDGET && rnd_done != 3'b111; i++) @(negedge clk);
    rnd_phase = 1'b0;
    checkOutput("rnd_done", 64'(rnd_done), 64'(3'b111));
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
